// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and helpers for the I2S/TDM transceiver.
//   I2S_MODE_I2S / I2S_MODE_LJ : framing mode selectors for the MODE parameter
//   clog2()                    : counter width helper (never returns less than 1)
package i2s_pkg;

  localparam int unsigned I2S_MODE_I2S = 0;
  localparam int unsigned I2S_MODE_LJ  = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: bit/frame clock generator for the I2S/TDM transceiver.
// Ports:
//   mclk, arstn  : master clock, asynchronous active-low reset
//   sclk, lrck   : bit clock and frame clock pins
//   rise_stb     : next mclk edge is an sclk rising edge
//   fall_stb     : next mclk edge is an sclk falling edge
//   frame_end    : next mclk edge is the falling edge that wraps the frame
//   load_next    : next mclk edge starts the cycle just before frame_end edge
//   last_bit     : current bit is the last bit of the frame
//   data_bit     : current bit carries data (not slot padding)
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned MCLK_DIV_SCLK = 4,
  parameter int unsigned SLOT_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned MODE          = I2S_MODE_I2S
) (
  input  logic mclk,
  input  logic arstn,
  output logic sclk,
  output logic lrck,
  output logic rise_stb,
  output logic fall_stb,
  output logic frame_end,
  output logic load_next,
  output logic last_bit,
  output logic data_bit
);

  localparam int unsigned F     = CHANNELS * SLOT_WIDTH;
  localparam int unsigned DIV_W = clog2(MCLK_DIV_SCLK);
  localparam int unsigned BIT_W = clog2(F);
  localparam int unsigned POS_W = clog2(SLOT_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(MCLK_DIV_SCLK - 1);
  localparam logic [DIV_W-1:0] DIV_PRE_RISE = DIV_W'(MCLK_DIV_SCLK / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_PRE_LOAD = DIV_W'(MCLK_DIV_SCLK - 2);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(F - 1);
  localparam logic [BIT_W-1:0] BIT_HALF     = BIT_W'(F / 2);
  localparam logic [BIT_W-1:0] BIT_PRE_HALF = BIT_W'(F / 2 - 1);
  localparam logic [POS_W-1:0] POS_LAST     = POS_W'(SLOT_WIDTH - 1);
  localparam logic [POS_W:0]   DW_LIM       = (POS_W + 1)'(DATA_WIDTH);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_nxt;
  logic [POS_W-1:0] slot_pos;
  logic             lrck_nxt;

  assign fall_stb  = (div_cnt == DIV_LAST);
  assign rise_stb  = (div_cnt == DIV_PRE_RISE);
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign frame_end = fall_stb & last_bit;
  assign load_next = (div_cnt == DIV_PRE_LOAD) & last_bit;
  assign data_bit  = ({1'b0, slot_pos} < DW_LIM);

  always_comb begin
    bit_nxt = bit_cnt;
    if (fall_stb) bit_nxt = last_bit ? '0 : bit_cnt + 1'b1;
  end

  // lrck is registered from the next bit count so it switches on the same
  // mclk edge as bit_cnt. I2S mode: high for bits F/2-1 .. F-2.
  always_comb begin
    lrck_nxt = 1'b0;
    if (MODE == I2S_MODE_LJ) lrck_nxt = (bit_nxt >= BIT_HALF);
    else                     lrck_nxt = (bit_nxt >= BIT_PRE_HALF) && (bit_nxt != BIT_LAST);
  end

  always_ff @(posedge mclk or negedge arstn) begin
    if (!arstn) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      slot_pos <= '0;
      sclk     <= 1'b0;
      lrck     <= 1'b0;
    end else begin
      bit_cnt <= bit_nxt;
      lrck    <= lrck_nxt;
      if (fall_stb) begin
        div_cnt  <= '0;
        sclk     <= 1'b0;
        slot_pos <= (slot_pos == POS_LAST || last_bit) ? '0 : slot_pos + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        if (rise_stb) sclk <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tdm.sv
// i2s_tdm: master-mode I2S / left-justified / TDM serial audio transceiver.
// Ports:
//   mclk, arstn         : master clock, asynchronous active-low reset
//   sclk, lrck          : generated bit and frame clocks
//   sdout, sdin         : serial transmit / receive data
//   tx_data, tx_valid   : transmit frame (channel 0 in LSBs) and its valid flag
//   tx_load             : pulse, tx_data/tx_valid sampled at end of this cycle
//   tx_underrun         : pulse, tx_valid was low at the last load
//   rx_data, rx_valid   : last received frame (channel 0 in LSBs), update pulse
module i2s_tdm
  import i2s_pkg::*;
#(
  parameter int unsigned MCLK_DIV_SCLK = 4,
  parameter int unsigned SLOT_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned MODE          = I2S_MODE_I2S
) (
  input  logic                           mclk,
  input  logic                           arstn,
  output logic                           sclk,
  output logic                           lrck,
  output logic                           sdout,
  input  logic                           sdin,
  input  logic [CHANNELS*DATA_WIDTH-1:0] tx_data,
  input  logic                           tx_valid,
  output logic                           tx_load,
  output logic                           tx_underrun,
  output logic [CHANNELS*DATA_WIDTH-1:0] rx_data,
  output logic                           rx_valid
);

  localparam int unsigned F  = CHANNELS * SLOT_WIDTH;
  localparam int unsigned FW = CHANNELS * DATA_WIDTH;

  if (CHANNELS < 2 || (CHANNELS % 2) != 0) begin : g_bad_channels
    $fatal(1, "i2s_tdm: CHANNELS must be even and at least 2");
  end
  if (MCLK_DIV_SCLK < 2 || (MCLK_DIV_SCLK % 2) != 0) begin : g_bad_div
    $fatal(1, "i2s_tdm: MCLK_DIV_SCLK must be even and at least 2");
  end
  if (DATA_WIDTH > SLOT_WIDTH || DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "i2s_tdm: DATA_WIDTH must be in 1..SLOT_WIDTH");
  end

  logic rise_stb, fall_stb, frame_end, load_next, last_bit, data_bit;

  i2s_clkgen #(
    .MCLK_DIV_SCLK (MCLK_DIV_SCLK),
    .SLOT_WIDTH    (SLOT_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .CHANNELS      (CHANNELS),
    .MODE          (MODE)
  ) u_clkgen (
    .mclk      (mclk),
    .arstn     (arstn),
    .sclk      (sclk),
    .lrck      (lrck),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .frame_end (frame_end),
    .load_next (load_next),
    .last_bit  (last_bit),
    .data_bit  (data_bit)
  );

  // Transmit frame in wire order: bit F-1 goes out first. Each slot holds
  // its channel word MSB-first followed by zero padding.
  logic [F-1:0]  tx_frame;
  logic [F-1:0]  tx_sreg;
  logic [FW-1:0] rx_sreg;
  logic [FW-1:0] rx_frame;
  logic          rx_done;

  always_comb begin
    tx_frame = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      tx_frame[F-1-c*SLOT_WIDTH -: DATA_WIDTH] = tx_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The receive shifter collects slot 0 first, so it ends up in the MSBs;
  // swap channel order back so channel 0 lands in the LSBs.
  always_comb begin
    rx_frame = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      rx_frame[c*DATA_WIDTH +: DATA_WIDTH] = rx_sreg[(CHANNELS-1-c)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sdout = tx_sreg[F-1];

  always_ff @(posedge mclk or negedge arstn) begin
    if (!arstn) begin
      tx_sreg     <= '0;
      tx_load     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_load     <= load_next;
      tx_underrun <= tx_load & ~tx_valid;
      if (frame_end)     tx_sreg <= tx_valid ? tx_frame : '0;
      else if (fall_stb) tx_sreg <= {tx_sreg[F-2:0], 1'b0};
    end
  end

  always_ff @(posedge mclk or negedge arstn) begin
    if (!arstn) begin
      rx_sreg  <= '0;
      rx_done  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_done;
      rx_done  <= rise_stb & last_bit;
      if (rise_stb && data_bit) rx_sreg <= {rx_sreg[FW-2:0], sdin};
      if (rx_done)              rx_data <= rx_frame;
    end
  end

endmodule

// File: tb/tb_i2s_tdm.sv
// tb_i2s_tdm: self-checking bench for i2s_tdm. Two loopback instances: a
// default two-channel I2S setup and an eight-slot TDM setup. Expected pin
// behaviour is derived from the absolute mclk count since reset release.
module tb_i2s_tdm;
  import i2s_pkg::*;

  logic mclk = 1'b0;
  logic arstn;
  always #5 mclk = ~mclk;

  logic        sclk0, lrck0, sdout0, load0, und0, rxv0, txv0;
  logic [47:0] txd0, rxd0;
  logic        sclk1, lrck1, sdout1, load1, und1, rxv1, txv1;
  logic [127:0] txd1, rxd1;

  i2s_tdm #(.MCLK_DIV_SCLK(4), .SLOT_WIDTH(32), .DATA_WIDTH(24), .CHANNELS(2),
            .MODE(I2S_MODE_I2S)) u0 (
    .mclk(mclk), .arstn(arstn), .sclk(sclk0), .lrck(lrck0), .sdout(sdout0),
    .sdin(sdout0), .tx_data(txd0), .tx_valid(txv0), .tx_load(load0),
    .tx_underrun(und0), .rx_data(rxd0), .rx_valid(rxv0));

  i2s_tdm #(.MCLK_DIV_SCLK(4), .SLOT_WIDTH(16), .DATA_WIDTH(16), .CHANNELS(8),
            .MODE(I2S_MODE_LJ)) u1 (
    .mclk(mclk), .arstn(arstn), .sclk(sclk1), .lrck(lrck1), .sdout(sdout1),
    .sdin(sdout1), .tx_data(txd1), .tx_valid(txv1), .tx_load(load1),
    .tx_underrun(und1), .rx_data(rxd1), .rx_valid(rxv1));

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int unsigned k;

  // Per instance, per frame: frame as seen on the wire (zero if not valid)
  logic [127:0] eff [2][16];
  bit           vld [2][16];

  int unsigned cfg_d    [2] = '{4, 4};
  int unsigned cfg_s    [2] = '{32, 16};
  int unsigned cfg_dw   [2] = '{24, 16};
  int unsigned cfg_ch   [2] = '{2, 8};
  int unsigned cfg_mode [2] = '{0, 1};

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chkw(tag, {127'b0, obs}, {127'b0, exp});
  endtask

  function automatic logic exp_bit(input int unsigned s, input int unsigned dw,
                                   input int unsigned b, input logic [127:0] frame);
    int unsigned slot;
    int unsigned pos;
    slot = b / s;
    pos  = b % s;
    if (pos >= dw) return 1'b0;
    return frame[slot*dw + dw - 1 - pos];
  endfunction

  task automatic check_dut(input int sel);
    int unsigned d, s, dw, ch, f, df, fr, ph, b, dv, rx_ph;
    logic o_sclk, o_lrck, o_sdout, o_load, o_und, o_rxv;
    logic [127:0] o_rx, e_rx;
    logic e_lrck, e_rxv;
    string nm;
    d = cfg_d[sel]; s = cfg_s[sel]; dw = cfg_dw[sel]; ch = cfg_ch[sel];
    f = ch * s; df = d * f; fr = k / df; ph = k % df; b = ph / d; dv = ph % d;
    rx_ph = (f - 1) * d + d / 2 + 1;
    if (sel == 0) begin
      nm = "i2s"; o_sclk = sclk0; o_lrck = lrck0; o_sdout = sdout0;
      o_load = load0; o_und = und0; o_rxv = rxv0; o_rx = {80'b0, rxd0};
    end else begin
      nm = "tdm"; o_sclk = sclk1; o_lrck = lrck1; o_sdout = sdout1;
      o_load = load1; o_und = und1; o_rxv = rxv1; o_rx = rxd1;
    end
    if (cfg_mode[sel] == 1) e_lrck = (b >= f / 2);
    else                    e_lrck = (((b + 1) % f) >= f / 2);
    e_rxv = (k >= rx_ph) && (((k - rx_ph) % df) == 0);
    e_rx  = (k >= rx_ph) ? eff[sel][(k - rx_ph) / df] : '0;
    chk1($sformatf("%s sclk k=%0d", nm, k), o_sclk, dv >= d / 2);
    chk1($sformatf("%s lrck k=%0d", nm, k), o_lrck, e_lrck);
    chk1($sformatf("%s tx_load k=%0d", nm, k), o_load, ph == df - 1);
    chk1($sformatf("%s tx_underrun k=%0d", nm, k), o_und, (k > 0) && (ph == 0) && !vld[sel][fr]);
    chk1($sformatf("%s sdout k=%0d", nm, k), o_sdout, exp_bit(s, dw, b, eff[sel][fr]));
    chk1($sformatf("%s rx_valid k=%0d", nm, k), o_rxv, e_rxv);
    chkw($sformatf("%s rx_data k=%0d", nm, k), o_rx, e_rx);
  endtask

  task automatic check_zero(input int sel, input string when);
    if (sel == 0) begin
      chk1({"i2s sclk ", when}, sclk0, 1'b0);
      chk1({"i2s lrck ", when}, lrck0, 1'b0);
      chk1({"i2s sdout ", when}, sdout0, 1'b0);
      chk1({"i2s tx_load ", when}, load0, 1'b0);
      chk1({"i2s tx_underrun ", when}, und0, 1'b0);
      chk1({"i2s rx_valid ", when}, rxv0, 1'b0);
      chkw({"i2s rx_data ", when}, {80'b0, rxd0}, '0);
    end else begin
      chk1({"tdm sclk ", when}, sclk1, 1'b0);
      chk1({"tdm lrck ", when}, lrck1, 1'b0);
      chk1({"tdm sdout ", when}, sdout1, 1'b0);
      chk1({"tdm tx_load ", when}, load1, 1'b0);
      chk1({"tdm tx_underrun ", when}, und1, 1'b0);
      chk1({"tdm rx_valid ", when}, rxv1, 1'b0);
      chkw({"tdm rx_data ", when}, rxd1, '0);
    end
  endtask

  // New transmit frame is presented right after each load edge, so it is
  // stable for the whole frame before the next load samples it.
  task automatic drive(input int sel);
    int unsigned df, nf;
    logic [127:0] w;
    bit v;
    df = cfg_d[sel] * cfg_ch[sel] * cfg_s[sel];
    if ((k % df) != 0) return;
    nf = k / df + 1;
    if (nf >= 16) return;
    w = {$urandom, $urandom, $urandom, $urandom};
    v = 1'b1;
    if (sel == 0) begin
      w[127:48] = '0;
      if (nf == 1) w[47:0] = {24'h123456, 24'hA5A5A5};
      if (nf == 3) v = 1'b0;
      txd0 = w[47:0];
      txv0 = v;
    end else begin
      if (nf == 1) for (int c = 0; c < 8; c++) w[c*16 +: 16] = 16'h1000 + 16'(c);
      txd1 = w;
      txv1 = v;
    end
    vld[sel][nf] = v;
    eff[sel][nf] = v ? w : '0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) begin
        eff[i][j] = '0;
        vld[i][j] = 1'b0;
      end
    end
    k = 0;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge mclk);
      k++;
      @(negedge mclk);
      check_dut(0);
      check_dut(1);
      drive(0);
      drive(1);
    end
  endtask

  initial begin
    int unsigned n;
    arstn = 1'b0;
    txd0 = '0; txv0 = 1'b0;
    txd1 = '0; txv1 = 1'b0;
    reset_model();

    repeat (3) begin
      @(negedge mclk);
      check_zero(0, "in reset");
      check_zero(1, "in reset");
    end

    arstn = 1'b1;
    check_dut(0); check_dut(1);
    drive(0); drive(1);
    run(1600);

    // Stop the I2S instance inside bit 40 while sclk is high
    n = (162 + 256 - (k % 256)) % 256;
    run(n);
    #2;
    arstn = 1'b0;
    #1;
    check_zero(0, "async reset");
    check_zero(1, "async reset");
    repeat (3) begin
      @(negedge mclk);
      check_zero(0, "held reset");
      check_zero(1, "held reset");
    end

    arstn = 1'b1;
    reset_model();
    check_dut(0); check_dut(1);
    drive(0); drive(1);
    run(600);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
